// File: rtl/store_pkg.sv
// store_pkg: shared byte-enable constants, drain FSM states and FIFO entry layout
//   for store_queue_ctrl and store_lane_fmt.
package store_pkg;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam int ENTRY_W = 66;
  typedef enum logic {ST_IDLE, ST_REQ} state_t;
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;
endpackage

// File: rtl/store_lane_fmt.sv
// store_lane_fmt: combinational store formatter (lane-replicated data, byte enables).
//   addr[1:0], data, sb, sh in; wdata, be, misaligned out.
//   misaligned is only computed with STORE_MISALIGN_TRAP_EN defined, otherwise 0.
module store_lane_fmt
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic        sb,
  input  logic        sh,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);
  // sh wins over sb when both are set
  always_comb begin
    wdata = sh ? {2{data[15:0]}} : sb ? {4{data[7:0]}} : data;
    be = sh ? (addr[1] ? BE_HALF_HI : BE_HALF_LO) : sb ? (BE_BYTE0 << addr) : BE_WORD;
`ifdef STORE_MISALIGN_TRAP_EN
    misaligned = sh ? addr[0] : (!sb && addr != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end
endmodule

// File: rtl/store_queue_ctrl.sv
// store_queue_ctrl: store buffer between execute and data-memory write port.
//   st_valid/st_ready/st_addr/st_data/st_sb/st_sh : store request in
//   mem_req/mem_addr/mem_wdata/mem_be/mem_ack     : req/ack memory write port
//   q_empty/q_count : occupancy; misalign_err : dropped-store pulse
//   Optional macro STORE_MISALIGN_TRAP_EN drops misaligned sh/word stores.
module store_queue_ctrl
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             st_sb,
  input  logic             st_sh,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  output logic             q_empty,
  output logic [CNT_W-1:0] q_count,
  output logic             misalign_err
);
  localparam int PTR_W = CNT_W - 1;
  entry_t q [DEPTH];
  entry_t head;
  state_t state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] count;
  logic [31:0] fmt_wdata;
  logic [3:0] fmt_be;
  logic fmt_mis, push, pop, load;
  store_lane_fmt u_fmt (
    .addr(st_addr[1:0]),
    .data(st_data),
    .sb(st_sb),
    .sh(st_sh),
    .wdata(fmt_wdata),
    .be(fmt_be),
    .misaligned(fmt_mis)
  );
  assign st_ready = count != CNT_W'(DEPTH);
  assign push = st_valid && st_ready && !fmt_mis;
  assign pop = state == ST_REQ && mem_ack;
  assign rd_nxt = rd_ptr + PTR_W'(1);
  assign q_count = count;
  assign q_empty = count == '0;
  // On ack the next head (if any) is loaded on the same edge, so REQ has no bubble
  always_comb begin
    mem_req = state == ST_REQ;
    head = pop ? q[rd_nxt] : q[rd_ptr];
    load = mem_req ? (pop && count > CNT_W'(1)) : (count != '0);
    state_nxt = (load || (mem_req && !mem_ack)) ? ST_REQ : ST_IDLE;
  end
  always_ff @(posedge clk)
    if (push) q[wr_ptr] <= '{st_addr[31:2], fmt_wdata, fmt_be};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_nxt;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (load) begin
        mem_addr <= {head.waddr, 2'b00};
        mem_wdata <= head.wdata;
        mem_be <= head.be;
      end
    end
`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign_err <= 1'b0;
    else misalign_err <= st_valid && st_ready && fmt_mis;
`else
  assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_store_queue_ctrl.sv
// tb_store_queue_ctrl: directed self-checking bench for store_queue_ctrl.
module tb_store_queue_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic st_valid = 1'b0, st_ready, st_sb = 1'b0, st_sh = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  logic mem_req, mem_ack = 1'b0, q_empty, misalign_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic [2:0] q_count;
  int errors = 0, checks = 0;
  store_queue_ctrl #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_sb(st_sb), .st_sh(st_sh),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .q_empty(q_empty), .q_count(q_count), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic b, input logic h);
    st_valid = v; st_addr = a; st_data = d; st_sb = b; st_sh = h;
  endtask
  initial begin
    tick(); tick();
    check("rst_req", mem_req, 0);
    check("rst_cnt", q_count, 0);
    check("rst_empty", q_empty, 1);
    check("rst_ready", st_ready, 1);
    check("rst_be", mem_be, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_err", misalign_err, 0);
    rst_n = 1'b1;
    tick();
    // sb to 0x1003, ack after two wait cycles
    drive(1, 32'h1003, 32'hAABBCCDD, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("sb_cnt", q_count, 1);
    check("sb_req_lat", mem_req, 0);
    tick();
    check("sb_req", mem_req, 1);
    check("sb_addr", mem_addr, 32'h1000);
    check("sb_be", mem_be, 4'b1000);
    check("sb_wdata", mem_wdata, 32'hDDDDDDDD);
    tick();
    check("sb_hold1", {mem_req, mem_addr}, {1'b1, 32'h1000});
    check("sb_hold1_d", mem_wdata, 32'hDDDDDDDD);
    tick();
    check("sb_hold2", {mem_req, mem_addr}, {1'b1, 32'h1000});
    check("sb_hold2_be", mem_be, 4'b1000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_done_req", mem_req, 0);
    check("sb_done_empty", q_empty, 1);
    // sh and sb both high: sh wins
    drive(1, 32'h2002, 32'h12345678, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    check("shb_addr", mem_addr, 32'h2000);
    check("shb_be", mem_be, 4'b1100);
    check("shb_wdata", mem_wdata, 32'h56785678);
    mem_ack = 1'b1;
    tick();
    // low halfword at 0x4000
    drive(1, 32'h4000, 32'hCAFEBEEF, 0, 1);
    mem_ack = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    check("shl_be", mem_be, 4'b0011);
    check("shl_wdata", mem_wdata, 32'hBEEFBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("shl_empty", q_empty, 1);
    // fill with 4 words, ack held low
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0);
      tick();
    end
    check("full_cnt", q_count, 4);
    check("full_ready", st_ready, 0);
    drive(1, 32'h200, 32'hDEAD, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("full_nopush", q_count, 4);
    check("full_head", mem_addr, 32'h100);
    mem_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("b2b_req", mem_req, 1);
      check("b2b_addr", mem_addr, 32'h100 + 32'(4 * i));
      check("b2b_data", mem_wdata, 32'hA0 + 32'(i));
      check("b2b_cnt", q_count, 32'(4 - i));
    end
    tick();
    mem_ack = 1'b0;
    check("b2b_end_req", mem_req, 0);
    check("b2b_empty", q_empty, 1);
    // pointers now both 0: push A,B,C to slots 0..2
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    mem_ack = 1'b1;
    tick();
    check("wr_pre_cnt", q_count, 2);
    check("wr_pre_addr", mem_addr, 32'h504);
    drive(1, 32'h50C, 32'hB3, 0, 0);
    tick();
    check("pp_cnt", q_count, 2);
    check("pp_addr", mem_addr, 32'h508);
    drive(1, 32'h510, 32'hB4, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("pp2_cnt", q_count, 2);
    check("pp2_addr", mem_addr, 32'h50C);
    tick();
    check("wrap_addr", mem_addr, 32'h510);
    check("wrap_data", mem_wdata, 32'hB4);
    check("wrap_cnt", q_count, 1);
    tick();
    mem_ack = 1'b0;
    check("wrap_empty", q_empty, 1);
    check("wrap_req", mem_req, 0);
    // misaligned word store
    drive(1, 32'h3001, 32'h11223344, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
`ifdef STORE_MISALIGN_TRAP_EN
    check("mis_cnt", q_count, 0);
    check("mis_err", misalign_err, 1);
    tick();
    check("mis_err_pulse", misalign_err, 0);
    check("mis_req", mem_req, 0);
`else
    check("mis_cnt", q_count, 1);
    check("mis_err", misalign_err, 0);
    tick();
    check("mis_addr", mem_addr, 32'h3000);
    check("mis_be", mem_be, 4'b1111);
    check("mis_data", mem_wdata, 32'h11223344);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
`endif
    check("mis_empty", q_empty, 1);
    // reset during REQ with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h600 + 32'(4 * i), 32'hC0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    check("pre_rst_req", mem_req, 1);
    check("pre_rst_cnt", q_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", mem_req, 0);
    check("async_cnt", q_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt", q_count, 0);
    check("post_rst_empty", q_empty, 1);
    tick();
    check("post_rst_req", mem_req, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
